mdu_ctrl: RTL and testbench
===========================

# mdu_ctrl

Sequencing controller between the execute stage and the multiply/divide unit. It accepts one M-extension request at a time over a valid/ready handshake and registers the operands, holding them stable for the whole operation. It issues a single-cycle start to the MDU, waits for its done pulse, and returns the tagged result over a second valid/ready handshake. It also handles pipeline flushes, a done-timeout watchdog and, optionally, a fast path for trivial operands.

## Interface
- TIMEOUT_CYCLES, 64: max cycles from mdu_start to mdu_done before the watchdog fires.
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  reset; **asynchronous, active-low**.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept; equals state==IDLE.
- req_op  in  3  MUL..REMU encoding (000..111).
- req_rs1 / req_rs2  in  32 each  operands X / Y.
- req_rd  in  5  destination tag, returned unchanged.
- flush  in  1  kill the in-flight request.
- resp_valid  out  1  result available.
- resp_ready  in  1  consumer accepts.
- resp_data  out  32  result.
- resp_rd  out  5  tag.
- resp_err  out  1  result produced by watchdog timeout.
- mdu_start  out  1  single-cycle start pulse to MDU.
- mdu_operation  out  3  registered op.
- mdu_x / mdu_y  out  32 each  registered operands.
- mdu_done  in  1  MDU completion pulse.
- mdu_result  in  32  MDU result; valid in the mdu_done cycle.
- busy  out  1  state != IDLE.

## Operation
- States: IDLE, WAIT, RESP, DRAIN.
- IDLE:
  - Accept on req_valid && req_ready && !flush.
  - Latch op, rs1, rs2 and rd.
  - If no fast path applies: mdu_start=1 for one cycle, then WAIT.
  - If a fast path applies: load the result directly and go to RESP.
- WAIT:
  - mdu_x, mdu_y and mdu_operation are held constant.
  - mdu_done: capture mdu_result, go to RESP.
  - flush without mdu_done: go to DRAIN.
  - flush together with mdu_done: discard the result, go to IDLE.
- RESP:
  - resp_valid=1; resp_data, resp_rd and resp_err are stable until handshake.
  - resp_ready: go to IDLE.
  - flush: drop the response, go to IDLE. Flush has priority over resp_ready.
- DRAIN:
  - Wait for mdu_done, discard the result, go to IDLE.
  - The MDU is not abortable, so no new request is accepted until the MDU is idle.
- Watchdog:
  - Counter cleared on issue, incremented in WAIT and DRAIN.
  - Reaching TIMEOUT_CYCLES in WAIT: resp_data=0, resp_err=1, go to RESP.
  - Reaching TIMEOUT_CYCLES in DRAIN: go to IDLE.
  - Counter width $clog2(TIMEOUT_CYCLES+1).
- mdu_done outside WAIT/DRAIN is ignored.
- Reset mid-operation: everything returns to IDLE; the MDU is reset by the same rst_n.
- Reset values: resp_valid=0, resp_data=0, resp_rd=0, resp_err=0, mdu_start=0, mdu_operation=0, mdu_x=0, mdu_y=0, busy=0. req_ready=1 once reset deasserts.

## Timing
- Request accepted in cycle N.
- MDU path: mdu_start is high in N+1 only. mdu_done arrives in cycle M. resp_valid is high from M+1.
- Fast path: resp_valid is high from N+1; mdu_start is never asserted.
- req_ready depends only on state, with no combinational path from req_valid or resp_ready.
- Minimum request-to-request spacing:
  - 2 cycles for the fast path with resp_ready held high.
  - Otherwise the MDU latency plus 2.
- All outputs are registered except req_ready and busy, which are decoded from state.

## Configuration
- MDU_FASTPATH_EN defined: the operand-class checks below complete in IDLE without touching the MDU.
  - MUL/MULH/MULHSU/MULHU with either operand 0: result 0.
  - DIV/DIVU with rs2=0: 0xFFFFFFFF.
  - REM/REMU with rs2=0: rs1.
  - DIV with rs1=0x80000000, rs2=0xFFFFFFFF: 0x80000000.
  - REM with the same operands: 0.
- MDU_FASTPATH_EN undefined: every request goes through the MDU. The fast-path logic is absent and MDU results are returned as-is.

## Structure
- mdu_pkg holds:
  - the op localparams (MUL..REMU);
  - the mdu_ctrl_state_t enum (IDLE/WAIT/RESP/DRAIN);
  - the fast-path constants (0xFFFFFFFF, 0x80000000).
- Sub-module mdu_fastpath:
  - purely combinational;
  - inputs op, rs1, rs2; outputs hit and value;
  - instantiated only under MDU_FASTPATH_EN.

## Test plan
- MUL 7×6 accepted, MDU model done after 10 cycles → exactly one mdu_start, resp_data=42, resp_rd echoed, resp_err=0.
- DIVU 100/7 with resp_ready held low for 5 cycles → resp_data=14 remains stable and resp_valid stays high until the handshake; req_ready=0 throughout.
- Flush 3 cycles after start, mdu_done 5 cycles later → no response, busy stays high until the done cycle, the next request is accepted the following cycle.
- Flush coincident with mdu_done in WAIT → no resp_valid, state is IDLE next cycle.
- Fast-path enabled:
  - DIV with rs2=0 → resp_valid at N+1 with 0xFFFFFFFF and no mdu_start.
  - REM with 0x80000000 / −1 → 0.
  - Fast-path disabled, DIV with rs2=0 → mdu_start is issued.
- MDU model never asserts done, TIMEOUT_CYCLES=64 → resp_valid with resp_err=1 and resp_data=0 after 64 WAIT cycles. Async reset asserted mid-WAIT → all outputs at reset values immediately.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared definitions for the M-extension sequencing controller: opcode
// encodings, controller state enum and the fixed results used by the
// optional operand fast path (macro MDU_FASTPATH_EN).
package mdu_pkg;

    // M-extension operation encodings as carried on req_op / mdu_operation
    localparam logic [2:0] MUL    = 3'd0;
    localparam logic [2:0] MULH   = 3'd1;
    localparam logic [2:0] MULHSU = 3'd2;
    localparam logic [2:0] MULHU  = 3'd3;
    localparam logic [2:0] DIV    = 3'd4;
    localparam logic [2:0] DIVU   = 3'd5;
    localparam logic [2:0] REM    = 3'd6;
    localparam logic [2:0] REMU   = 3'd7;

    // Controller states; exported on the top-level state port for checkers
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        RESP  = 2'd2,
        DRAIN = 2'd3
    } mdu_ctrl_state_t;

    // Architecturally defined results for divide-by-zero and signed overflow
    localparam logic [31:0] FP_ALL_ONES = 32'hFFFF_FFFF;
    localparam logic [31:0] FP_INT_MIN  = 32'h8000_0000;

    // Multiply family occupies the lower half of the encoding space
    function automatic logic is_mul_op(input logic [2:0] op);
        return !op[2];
    endfunction

endpackage

// File: rtl/mdu_ctrl_if.sv
// Bundle of request, response and MDU-side signals of mdu_ctrl.
//
// Handshake semantics (both req_* and resp_* channels): a transfer happens on
// the rising edge where valid && ready are both high. Once valid is raised the
// payload stays stable until that edge; valid never depends combinationally
// on ready. flush kills whatever request the controller holds and has priority
// over a response handshake in the same cycle.
interface mdu_ctrl_if;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic [31:0] req_rs1;
    logic [31:0] req_rs2;
    logic [4:0]  req_rd;
    logic        flush;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_data;
    logic [4:0]  resp_rd;
    logic        resp_err;
    logic        mdu_start;
    logic [2:0]  mdu_operation;
    logic [31:0] mdu_x;
    logic [31:0] mdu_y;
    logic        mdu_done;
    logic [31:0] mdu_result;
    logic        busy;

    // Controller view
    modport slave (
        input  req_valid, req_op, req_rs1, req_rs2, req_rd, flush,
        input  resp_ready, mdu_done, mdu_result,
        output req_ready, resp_valid, resp_data, resp_rd, resp_err,
        output mdu_start, mdu_operation, mdu_x, mdu_y, busy
    );

    // Execute stage plus MDU view
    modport master (
        output req_valid, req_op, req_rs1, req_rs2, req_rd, flush,
        output resp_ready, mdu_done, mdu_result,
        input  req_ready, resp_valid, resp_data, resp_rd, resp_err,
        input  mdu_start, mdu_operation, mdu_x, mdu_y, busy
    );
endinterface

// File: rtl/mdu_fastpath.sv
// Combinational operand-class detector for mdu_ctrl, used only when
// MDU_FASTPATH_EN is defined. Flags requests whose result is fixed by the
// operands alone (zero multiplicand, divide by zero, signed overflow).
module mdu_fastpath
    import mdu_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [31:0] rs1,
    input  logic [31:0] rs2,
    output logic        hit,
    output logic [31:0] value
);

    logic rs2_zero;
    logic sovf;

    assign rs2_zero = (rs2 == 32'd0);
    assign sovf     = (rs1 == FP_INT_MIN) && (rs2 == FP_ALL_ONES);

    // Classify the operands and pick the architecturally fixed result
    always_comb begin
        hit   = 1'b0;
        value = 32'd0;
        if (is_mul_op(op)) begin
            if ((rs1 == 32'd0) || rs2_zero) begin
                hit   = 1'b1;
                value = 32'd0;
            end
        end else begin
            case (op)
                DIV: begin
                    if (rs2_zero) begin
                        hit   = 1'b1;
                        value = FP_ALL_ONES;
                    end else if (sovf) begin
                        hit   = 1'b1;
                        value = FP_INT_MIN;
                    end
                end
                DIVU: begin
                    if (rs2_zero) begin
                        hit   = 1'b1;
                        value = FP_ALL_ONES;
                    end
                end
                REM: begin
                    if (rs2_zero) begin
                        hit   = 1'b1;
                        value = rs1;
                    end else if (sovf) begin
                        hit   = 1'b1;
                        value = 32'd0;
                    end
                end
                REMU: begin
                    if (rs2_zero) begin
                        hit   = 1'b1;
                        value = rs1;
                    end
                end
                default: begin
                    hit   = 1'b0;
                    value = 32'd0;
                end
            endcase
        end
    end

endmodule

// File: rtl/mdu_ctrl.sv
// Sequencing controller between execute and the multiply/divide unit.
// Accepts one request, registers the operands, pulses mdu_start, waits for
// mdu_done (guarded by a watchdog) and returns the tagged result. Flushes
// either drop the pending response or drain the non-abortable MDU.
// Optional feature: define MDU_FASTPATH_EN to resolve trivial operand
// classes in IDLE without starting the MDU.
module mdu_ctrl
    import mdu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    mdu_ctrl_if.slave       bus,
    output mdu_ctrl_state_t state
);

    localparam int          CW       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    mdu_ctrl_state_t state_q;
    mdu_ctrl_state_t state_d;
    logic [CW-1:0]   cnt_q;
    logic            accept;
    logic            wd_expired;
    logic            fp_hit;
    logic [31:0]     fp_value;

`ifdef MDU_FASTPATH_EN
    mdu_fastpath u_fastpath (
        .op    (bus.req_op),
        .rs1   (bus.req_rs1),
        .rs2   (bus.req_rs2),
        .hit   (fp_hit),
        .value (fp_value)
    );
`else
    assign fp_hit   = 1'b0;
    assign fp_value = 32'd0;
`endif

    // req_ready and busy are pure state decodes so upstream sees no
    // combinational path from req_valid or resp_ready
    assign bus.req_ready = (state_q == IDLE);
    assign bus.busy      = (state_q != IDLE);
    assign state         = state_q;

    assign accept     = bus.req_valid && (state_q == IDLE) && !bus.flush;
    // Counter holds the number of WAIT/DRAIN cycles already spent, so this
    // fires on the TIMEOUT_CYCLES-th cycle after issue
    assign wd_expired = (cnt_q == CNT_LAST);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state decode; mdu_done is ignored outside WAIT/DRAIN
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) state_d = fp_hit ? RESP : WAIT;
            end
            WAIT: begin
                if (bus.mdu_done)     state_d = bus.flush ? IDLE : RESP;
                else if (bus.flush)   state_d = DRAIN;
                else if (wd_expired)  state_d = RESP;
            end
            RESP: begin
                if (bus.flush || bus.resp_ready) state_d = IDLE;
            end
            DRAIN: begin
                if (bus.mdu_done || wd_expired) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Watchdog counter: cleared on issue, counts while the MDU is running
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (accept) begin
            cnt_q <= '0;
        end else if ((state_q == WAIT) || (state_q == DRAIN)) begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

    // Registered outputs: operand hold, start pulse and response payload
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.mdu_start     <= 1'b0;
            bus.mdu_operation <= 3'd0;
            bus.mdu_x         <= 32'd0;
            bus.mdu_y         <= 32'd0;
            bus.resp_valid    <= 1'b0;
            bus.resp_data     <= 32'd0;
            bus.resp_rd       <= 5'd0;
            bus.resp_err      <= 1'b0;
        end else begin
            bus.mdu_start  <= accept && !fp_hit;
            bus.resp_valid <= (state_d == RESP);
            if (accept) begin
                bus.mdu_operation <= bus.req_op;
                bus.mdu_x         <= bus.req_rs1;
                bus.mdu_y         <= bus.req_rs2;
                bus.resp_rd       <= bus.req_rd;
            end
            if (accept && fp_hit) begin
                bus.resp_data <= fp_value;
                bus.resp_err  <= 1'b0;
            end else if ((state_q == WAIT) && !bus.flush) begin
                if (bus.mdu_done) begin
                    bus.resp_data <= bus.mdu_result;
                    bus.resp_err  <= 1'b0;
                end else if (wd_expired) begin
                    bus.resp_data <= 32'd0;
                    bus.resp_err  <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Self-checking bench for mdu_ctrl with a behavioural MDU model and a
// reference model of the M-extension results.
module tb_mdu_ctrl;
    import mdu_pkg::*;

    localparam int TO = 64;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mdu_ctrl_if bus();
    mdu_ctrl_state_t dut_state;

    mdu_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .state (dut_state)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int mdu_lat = 4;
    bit mdu_hang = 1'b0;
    int start_cnt = 0;
    logic [36:0] exp_q[$];

    initial begin
        #500000;
        $display("FAIL global_timeout");
        $fatal(1, "simulation time limit");
    end

    // ---------------- reference model ----------------
    function automatic logic [31:0] ref_result(input logic [2:0] op,
                                               input logic [31:0] a,
                                               input logic [31:0] b);
        longint sa, sb;
        longint unsigned ua, ub;
        logic [63:0] p;
        logic [31:0] r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        r  = 32'd0;
        case (op)
            3'd0: begin p = ua * ub; r = p[31:0]; end
            3'd1: begin p = sa * sb; r = p[63:32]; end
            3'd2: begin p = sa * longint'(ub); r = p[63:32]; end
            3'd3: begin p = ua * ub; r = p[63:32]; end
            3'd4: begin
                if (b == 32'd0) r = 32'hFFFF_FFFF;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'h8000_0000;
                else begin p = sa / sb; r = p[31:0]; end
            end
            3'd5: r = (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 32'd0) r = a;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'd0;
                else begin p = sa % sb; r = p[31:0]; end
            end
            default: r = (b == 32'd0) ? a : a % b;
        endcase
        return r;
    endfunction

`ifdef MDU_FASTPATH_EN
    function automatic bit fast_hit(input logic [2:0] op, input logic [31:0] a,
                                    input logic [31:0] b);
        if (op < 3'd4) return (a == 32'd0) || (b == 32'd0);
        if (b == 32'd0) return 1'b1;
        if ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
            return 1'b1;
        return 1'b0;
    endfunction
`endif

    // ---------------- MDU model ----------------
    initial begin
        logic [31:0] r;
        bus.mdu_done   = 1'b0;
        bus.mdu_result = 32'd0;
        forever begin
            @(posedge clk); #1;
            if (bus.mdu_start === 1'b1 && !mdu_hang) begin
                r = ref_result(bus.mdu_operation, bus.mdu_x, bus.mdu_y);
                repeat (mdu_lat) @(posedge clk);
                #1;
                bus.mdu_done   = 1'b1;
                bus.mdu_result = r;
                @(posedge clk); #1;
                bus.mdu_done   = 1'b0;
                bus.mdu_result = $urandom;
            end
        end
    end

    always @(negedge clk) if (bus.mdu_start === 1'b1) start_cnt++;

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk); #1;
    endtask

    // Presents a request and returns one cycle after the accepting edge
    task automatic issue(input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd,
                         output int waited);
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_rs1   = a;
        bus.req_rs2   = b;
        bus.req_rd    = rd;
        waited = 0;
        while (bus.req_ready !== 1'b1 && waited < 200) begin
            step();
            waited++;
        end
        if (waited >= 200) begin
            n_tests++; n_fail++;
            $display("FAIL issue_timeout: req_ready never high");
        end
        step();
        bus.req_valid = 1'b0;
    endtask

    task automatic wait_resp(output int cyc);
        cyc = 0;
        while (bus.resp_valid !== 1'b1 && cyc < 300) begin
            step();
            cyc++;
        end
        if (cyc >= 300) begin
            n_tests++; n_fail++;
            $display("FAIL resp_timeout: resp_valid never high");
        end
    endtask

    task automatic handshake();
        bus.resp_ready = 1'b1;
        step();
        bus.resp_ready = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) step();
        n_tests++;
        if ({bus.resp_valid, bus.resp_data, bus.resp_rd, bus.resp_err, bus.mdu_start,
             bus.mdu_operation, bus.mdu_x, bus.mdu_y, bus.busy} !== 108'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got valid=%b data=%h rd=%h err=%b start=%b busy=%b, want all 0",
                     bus.resp_valid, bus.resp_data, bus.resp_rd, bus.resp_err, bus.mdu_start, bus.busy);
        end
        rst_n = 1'b1;
        step();
        n_tests++;
        if (bus.req_ready !== 1'b1 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ready: req_ready=%b busy=%b, want 1/0", bus.req_ready, bus.busy);
        end
    endtask

    task automatic test_mul();
        int w, cyc, s0;
        mdu_lat = 10;
        s0 = start_cnt;
        issue(MUL, 32'd7, 32'd6, 5'd9, w);
        n_tests++;
        if ({bus.mdu_start, bus.mdu_operation, bus.mdu_x, bus.mdu_y} !== {1'b1, MUL, 32'd7, 32'd6}) begin
            n_fail++;
            $display("FAIL mul_issue: start=%b op=%0d x=%0d y=%0d, want 1/0/7/6",
                     bus.mdu_start, bus.mdu_operation, bus.mdu_x, bus.mdu_y);
        end
        wait_resp(cyc);
        n_tests++;
        if (cyc !== mdu_lat + 1) begin
            n_fail++;
            $display("FAIL mul_latency: resp after %0d cycles, want %0d", cyc, mdu_lat + 1);
        end
        n_tests++;
        if ({bus.resp_data, bus.resp_rd, bus.resp_err} !== {32'd42, 5'd9, 1'b0}) begin
            n_fail++;
            $display("FAIL mul_resp: data=%0d rd=%0d err=%b, want 42/9/0",
                     bus.resp_data, bus.resp_rd, bus.resp_err);
        end
        n_tests++;
        if (start_cnt - s0 !== 1) begin
            n_fail++;
            $display("FAIL mul_starts: %0d start cycles, want 1", start_cnt - s0);
        end
        handshake();
        n_tests++;
        if (bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL mul_after: resp_valid=%b req_ready=%b, want 0/1", bus.resp_valid, bus.req_ready);
        end
    endtask

    task automatic test_backpressure();
        int w, cyc;
        mdu_lat = 4;
        issue(DIVU, 32'd100, 32'd7, 5'd3, w);
        wait_resp(cyc);
        for (int i = 0; i < 5; i++) begin
            n_tests++;
            if ({bus.resp_valid, bus.resp_data, bus.resp_rd, bus.req_ready} !== {1'b1, 32'd14, 5'd3, 1'b0}) begin
                n_fail++;
                $display("FAIL bp_hold[%0d]: valid=%b data=%0d rd=%0d req_ready=%b, want 1/14/3/0",
                         i, bus.resp_valid, bus.resp_data, bus.resp_rd, bus.req_ready);
            end
            step();
        end
        handshake();
        n_tests++;
        if (bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_release: resp_valid=%b req_ready=%b, want 0/1", bus.resp_valid, bus.req_ready);
        end
    endtask

    task automatic test_flush_drain();
        int w, cyc, bad;
        logic [31:0] a, b;
        mdu_lat = 8;
        issue(MUL, $urandom | 32'd1, $urandom | 32'd1, 5'd4, w);
        repeat (3) step();
        bus.flush = 1'b1;
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            if (bus.busy !== 1'b1 || bus.resp_valid !== 1'b0) bad++;
            step();
            bus.flush = 1'b0;
        end
        n_tests++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL drain_busy: %0d bad cycles, want busy=1 resp_valid=0 throughout", bad);
        end
        n_tests++;
        if (bus.busy !== 1'b0 || bus.req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL drain_exit: busy=%b req_ready=%b after done, want 0/1", bus.busy, bus.req_ready);
        end
        a = $urandom_range(1, 60000);
        b = $urandom_range(1, 60000);
        mdu_lat = $urandom_range(1, 6);
        issue(MUL, a, b, 5'd17, w);
        n_tests++;
        if (w !== 0) begin
            n_fail++;
            $display("FAIL drain_next_accept: accepted after %0d waits, want 0", w);
        end
        wait_resp(cyc);
        n_tests++;
        if ({bus.resp_data, bus.resp_rd} !== {ref_result(MUL, a, b), 5'd17}) begin
            n_fail++;
            $display("FAIL drain_next_resp: data=%h rd=%0d, want %h/17",
                     bus.resp_data, bus.resp_rd, ref_result(MUL, a, b));
        end
        handshake();
    endtask

    task automatic test_flush_coincident();
        int w, bad;
        mdu_lat = 5;
        issue(DIVU, $urandom, $urandom_range(1, 1000), 5'd6, w);
        repeat (5) step();
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        n_tests++;
        if ({bus.resp_valid, bus.busy, bus.req_ready} !== 3'b001) begin
            n_fail++;
            $display("FAIL coinc_idle: valid=%b busy=%b ready=%b, want 0/0/1",
                     bus.resp_valid, bus.busy, bus.req_ready);
        end
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (bus.resp_valid !== 1'b0) bad++;
        end
        n_tests++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL coinc_no_resp: resp_valid high in %0d cycles, want 0", bad);
        end
    endtask

    task automatic test_special_operands();
        int w, cyc, s0;
        logic [2:0]  ops[3];
        logic [31:0] as[3];
        logic [31:0] bs[3];
        ops[0] = DIV; as[0] = $urandom;       bs[0] = 32'd0;
        ops[1] = REM; as[1] = 32'h8000_0000;  bs[1] = 32'hFFFF_FFFF;
        ops[2] = MUL; as[2] = $urandom;       bs[2] = 32'd0;
        mdu_lat = 3;
        for (int i = 0; i < 3; i++) begin
            s0 = start_cnt;
            issue(ops[i], as[i], bs[i], 5'(i + 20), w);
            wait_resp(cyc);
            n_tests++;
            if ({bus.resp_data, bus.resp_rd, bus.resp_err} !== {ref_result(ops[i], as[i], bs[i]), 5'(i + 20), 1'b0}) begin
                n_fail++;
                $display("FAIL special_data[%0d]: data=%h rd=%0d err=%b, want %h/%0d/0",
                         i, bus.resp_data, bus.resp_rd, bus.resp_err, ref_result(ops[i], as[i], bs[i]), i + 20);
            end
            handshake();
`ifdef MDU_FASTPATH_EN
            n_tests++;
            if (cyc !== 0 || start_cnt - s0 !== 0) begin
                n_fail++;
                $display("FAIL special_fast[%0d]: latency=%0d starts=%0d, want 0/0", i, cyc, start_cnt - s0);
            end
`else
            n_tests++;
            if (cyc !== mdu_lat + 1 || start_cnt - s0 !== 1) begin
                n_fail++;
                $display("FAIL special_mdu[%0d]: latency=%0d starts=%0d, want %0d/1",
                         i, cyc, start_cnt - s0, mdu_lat + 1);
            end
`endif
        end
    endtask

    task automatic test_random();
        int w, cyc, s0, exp_starts, bad;
        logic [2:0]  op;
        logic [31:0] a, b;
        logic [4:0]  rd;
        logic [36:0] e;
        s0 = start_cnt;
        exp_starts = 0;
        bad = 0;
        for (int i = 0; i < 24; i++) begin
            op = 3'($urandom_range(0, 7));
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 5))
                0: b = 32'd0;
                1: a = 32'd0;
                2: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                default: ;
            endcase
            rd = 5'($urandom_range(0, 31));
            mdu_lat = $urandom_range(1, 12);
            exp_q.push_back({rd, ref_result(op, a, b)});
`ifdef MDU_FASTPATH_EN
            if (!fast_hit(op, a, b)) exp_starts++;
`else
            exp_starts++;
`endif
            issue(op, a, b, rd, w);
            wait_resp(cyc);
            repeat ($urandom_range(0, 3)) step();
            e = exp_q.pop_front();
            n_tests++;
            if ({bus.resp_rd, bus.resp_data, bus.resp_err} !== {e, 1'b0}) begin
                n_fail++;
                bad++;
                $display("FAIL rand[%0d] op=%0d a=%h b=%h: rd=%0d data=%h err=%b, want %0d/%h/0",
                         i, op, a, b, bus.resp_rd, bus.resp_data, bus.resp_err, e[36:32], e[31:0]);
            end
            handshake();
        end
        n_tests++;
        if (start_cnt - s0 !== exp_starts) begin
            n_fail++;
            $display("FAIL rand_starts: %0d start pulses, want %0d", start_cnt - s0, exp_starts);
        end
    endtask

    task automatic test_timeout();
        int w, cyc;
        mdu_hang = 1'b1;
        issue(MULHU, $urandom | 32'd1, $urandom | 32'd1, 5'd11, w);
        wait_resp(cyc);
        n_tests++;
        if (cyc !== TO) begin
            n_fail++;
            $display("FAIL timeout_latency: resp after %0d cycles, want %0d", cyc, TO);
        end
        n_tests++;
        if ({bus.resp_data, bus.resp_rd, bus.resp_err} !== {32'd0, 5'd11, 1'b1}) begin
            n_fail++;
            $display("FAIL timeout_resp: data=%h rd=%0d err=%b, want 0/11/1",
                     bus.resp_data, bus.resp_rd, bus.resp_err);
        end
        handshake();
    endtask

    task automatic test_reset_mid_wait();
        int w, cyc;
        mdu_hang = 1'b1;
        issue(DIV, 32'h0000_1234, 32'd5, 5'd30, w);
        repeat (10) step();
        n_tests++;
        if (bus.busy !== 1'b1 || bus.mdu_x !== 32'h0000_1234) begin
            n_fail++;
            $display("FAIL rst_pre: busy=%b x=%h, want 1/00001234", bus.busy, bus.mdu_x);
        end
        rst_n = 1'b0;
        #1;
        n_tests++;
        if ({bus.resp_valid, bus.resp_data, bus.resp_rd, bus.resp_err, bus.mdu_start,
             bus.mdu_operation, bus.mdu_x, bus.mdu_y, bus.busy} !== 108'd0) begin
            n_fail++;
            $display("FAIL rst_async: valid=%b data=%h rd=%0d op=%0d x=%h y=%h busy=%b, want all 0",
                     bus.resp_valid, bus.resp_data, bus.resp_rd, bus.mdu_operation,
                     bus.mdu_x, bus.mdu_y, bus.busy);
        end
        step();
        rst_n = 1'b1;
        mdu_hang = 1'b0;
        step();
        n_tests++;
        if (bus.req_ready !== 1'b1 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_release: req_ready=%b busy=%b, want 1/0", bus.req_ready, bus.busy);
        end
        mdu_lat = 2;
        issue(MUL, 32'd3, 32'd5, 5'd1, w);
        wait_resp(cyc);
        n_tests++;
        if (bus.resp_data !== 32'd15) begin
            n_fail++;
            $display("FAIL rst_recover: data=%0d, want 15", bus.resp_data);
        end
        handshake();
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        bus.req_valid  = 1'b0;
        bus.req_op     = 3'd0;
        bus.req_rs1    = 32'd0;
        bus.req_rs2    = 32'd0;
        bus.req_rd     = 5'd0;
        bus.flush      = 1'b0;
        bus.resp_ready = 1'b0;
        test_reset();
        test_mul();
        test_backpressure();
        test_flush_drain();
        test_flush_coincident();
        test_special_operands();
        test_random();
        test_timeout();
        test_reset_mid_wait();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
